ddr3_burst_arbiter: RTL and testbench

Multi-channel burst front-end for the Gowin DDR3 memory-interface user port, in the i_ddr3_clk domain.
Accepts whole-burst read or write requests from N_CH clients (MJPEG frame store, readback to UDP, ...) and arbitrates among them round-robin.
Expands each granted request into BURST_LEN single-beat DDR3 commands at consecutive addresses and routes read data back to the owning channel.

---
 rtl/ddr3_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/ddr3_burst_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ddr3_burst_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 burst arbiter.
// Optional build macro: DDR3_ARB_PRIO0_EN (see rr_arbiter.sv).
package ddr3_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  localparam logic [2:0] DDR3_CMD_WR = 3'b000;
  localparam logic [2:0] DDR3_CMD_RD = 3'b001;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: grants the first requester at or after ptr,
// wrapping around. Optional build macro DDR3_ARB_PRIO0_EN gives channel 0
// strict priority; the remaining channels then share the round-robin.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

`ifdef DDR3_ARB_PRIO0_EN
  localparam int RR_LO = 1;
`else
  localparam int RR_LO = 0;
`endif

  // Two passes: first ptr..N-1, then the wrapped part below ptr.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
`ifdef DDR3_ARB_PRIO0_EN
    if (req[0]) begin
      grant[0]    = 1'b1;
      grant_valid = 1'b1;
    end
`endif
    for (int j = RR_LO; j < N; j++) begin
      if (!grant_valid && req[j] && (j >= int'(ptr))) begin
        grant[j]    = 1'b1;
        grant_idx   = IDX_W'(j);
        grant_valid = 1'b1;
      end
    end
    for (int j = RR_LO; j < N; j++) begin
      if (!grant_valid && req[j] && (j < int'(ptr))) begin
        grant[j]    = 1'b1;
        grant_idx   = IDX_W'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_burst_arbiter.sv
// Multi-channel burst front-end for the Gowin DDR3 user port. Arbitrates
// whole-burst requests, expands each into single-beat commands at
// consecutive addresses and steers read data back to the owning channel.
// Optional build macro: DDR3_ARB_PRIO0_EN (channel 0 strict priority).
module ddr3_burst_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int ADDR_STEP = 8
) (
  input  logic                   i_ddr3_clk,
  input  logic                   i_rst_n,
  input  logic [N_CH-1:0]        i_ch_req,
  input  logic [N_CH-1:0]        i_ch_wr,
  input  logic [N_CH*ADDR_W-1:0] i_ch_addr,
  input  logic [N_CH*DATA_W-1:0] i_ch_wr_data,
  output logic [N_CH-1:0]        o_ch_grant,
  output logic [N_CH-1:0]        o_ch_wr_data_req,
  output logic [DATA_W-1:0]      o_ch_rd_data,
  output logic [N_CH-1:0]        o_ch_rd_valid,
  output logic [N_CH-1:0]        o_ch_done,
  output logic [2:0]             o_ddr3_cmd,
  output logic                   o_ddr3_cmd_en,
  output logic [ADDR_W-1:0]      o_ddr3_addr,
  output logic [DATA_W-1:0]      o_ddr3_wr_data,
  output logic                   o_ddr3_wr_data_en,
  output logic                   o_ddr3_wr_data_end,
  output logic [DATA_W/8-1:0]    o_ddr3_wr_mask,
  input  logic                   i_ddr3_cmd_ready,
  input  logic                   i_ddr3_wr_data_rdy,
  input  logic [DATA_W-1:0]      i_ddr3_rd_data,
  input  logic                   i_ddr3_rd_data_de,
  input  logic                   i_ddr3_rd_data_end
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam int IDX_W = idx_width(N_CH);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

  arb_state_t         state;
  arb_state_t         next_state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ch_idx;
  logic [ADDR_W-1:0]  cur_addr;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   ret_cnt;
  logic [N_CH-1:0]    grant_q;
  logic [N_CH-1:0]    rd_valid_q;
  logic [DATA_W-1:0]  rd_data_q;

  logic [N_CH-1:0]    arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               req_wr;
  logic [ADDR_W-1:0]  req_addr;
  logic [N_CH-1:0]    owner;
  logic [DATA_W-1:0]  owner_wr_data;
  logic               wr_fire;
  logic               rd_fire;
  logic               rd_accept;

  // Every read beat is its own burst, so the end marker carries no information.
  logic unused_rd_end;
  assign unused_rd_end = i_ddr3_rd_data_end;

  rr_arbiter #(
    .N     (N_CH),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req         (i_ch_req),
    .ptr         (ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // A write beat needs both command and data slots; a read only the command slot.
  assign wr_fire   = (state == WR) && i_ddr3_cmd_ready && i_ddr3_wr_data_rdy;
  assign rd_fire   = (state == RD) && i_ddr3_cmd_ready;
  assign rd_accept = i_ddr3_rd_data_de && (state != IDLE);

  // Pick out direction/address of the winning requester and data of the owner.
  always_comb begin
    req_wr        = 1'b0;
    req_addr      = '0;
    owner         = '0;
    owner_wr_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (arb_grant[c]) begin
        req_wr   = i_ch_wr[c];
        req_addr = i_ch_addr[c*ADDR_W +: ADDR_W];
      end
      if (ch_idx == IDX_W'(c)) begin
        owner[c]      = 1'b1;
        owner_wr_data = i_ch_wr_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic: one burst at a time, always returning through DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_valid) next_state = req_wr ? WR : RD;
      WR:      if (wr_fire && (beat_cnt == LAST_BEAT)) next_state = DONE;
      RD:      if (rd_fire && (beat_cnt == LAST_BEAT)) next_state = RWAIT;
      RWAIT:   if (ret_cnt == FULL_CNT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: strobes only in cycles where the IP takes the beat.
  always_comb begin
    o_ddr3_cmd_en      = wr_fire | rd_fire;
    o_ddr3_cmd         = (state == RD) ? DDR3_CMD_RD : DDR3_CMD_WR;
    o_ddr3_addr        = cur_addr;
    o_ddr3_wr_data_en  = wr_fire;
    o_ddr3_wr_data_end = wr_fire;
    o_ddr3_wr_data     = wr_fire ? owner_wr_data : '0;
    o_ddr3_wr_mask     = '0;
    o_ch_wr_data_req   = wr_fire ? owner : '0;
    o_ch_done          = (state == DONE) ? owner : '0;
    o_ch_grant         = grant_q;
    o_ch_rd_valid      = rd_valid_q;
    o_ch_rd_data       = rd_data_q;
  end

  // Burst bookkeeping: latch the winner on grant, then count issued and returned beats.
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      ch_idx   <= '0;
      cur_addr <= '0;
      beat_cnt <= '0;
      ret_cnt  <= '0;
      grant_q  <= '0;
    end else begin
      grant_q <= '0;
      if ((state == IDLE) && arb_valid) begin
        grant_q  <= arb_grant;
        ch_idx   <= arb_idx;
        cur_addr <= req_addr;
        beat_cnt <= '0;
        ret_cnt  <= '0;
        ptr      <= (arb_idx == IDX_W'(N_CH - 1)) ? '0 : arb_idx + IDX_W'(1);
      end else begin
        if (wr_fire || rd_fire) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          cur_addr <= cur_addr + STEP;
        end
        if (rd_accept) ret_cnt <= ret_cnt + CNT_W'(1);
      end
    end
  end

  // Read return path: one-cycle registered copy steered to the owning channel.
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_accept ? owner : '0;
      if (rd_accept) rd_data_q <= i_ddr3_rd_data;
    end
  end

endmodule

// File: tb/tb_ddr3_burst_arbiter.sv
// Directed bench for ddr3_burst_arbiter (N_CH=2, BURST_LEN=4): write bursts
// from a vector table, then hand-written read, fairness and reset sequences.
module tb_ddr3_burst_arbiter;

  localparam int N_CH   = 2;
  localparam int BL     = 4;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_CH-1:0]        ch_req;
  logic [N_CH-1:0]        ch_wr;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*DATA_W-1:0] ch_wr_data;
  logic [N_CH-1:0]        ch_grant;
  logic [N_CH-1:0]        ch_wr_data_req;
  logic [DATA_W-1:0]      ch_rd_data;
  logic [N_CH-1:0]        ch_rd_valid;
  logic [N_CH-1:0]        ch_done;
  logic [2:0]             ddr3_cmd;
  logic                   ddr3_cmd_en;
  logic [ADDR_W-1:0]      ddr3_addr;
  logic [DATA_W-1:0]      ddr3_wr_data;
  logic                   ddr3_wr_data_en;
  logic                   ddr3_wr_data_end;
  logic [DATA_W/8-1:0]    ddr3_wr_mask;
  logic                   cmd_rdy;
  logic                   wr_rdy;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_de;
  logic                   rd_end;

  int n_checks = 0;
  int n_fail   = 0;

  ddr3_burst_arbiter #(
    .N_CH(N_CH), .BURST_LEN(BL), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(8)
  ) dut (
    .i_ddr3_clk         (clk),
    .i_rst_n            (rst_n),
    .i_ch_req           (ch_req),
    .i_ch_wr            (ch_wr),
    .i_ch_addr          (ch_addr),
    .i_ch_wr_data       (ch_wr_data),
    .o_ch_grant         (ch_grant),
    .o_ch_wr_data_req   (ch_wr_data_req),
    .o_ch_rd_data       (ch_rd_data),
    .o_ch_rd_valid      (ch_rd_valid),
    .o_ch_done          (ch_done),
    .o_ddr3_cmd         (ddr3_cmd),
    .o_ddr3_cmd_en      (ddr3_cmd_en),
    .o_ddr3_addr        (ddr3_addr),
    .o_ddr3_wr_data     (ddr3_wr_data),
    .o_ddr3_wr_data_en  (ddr3_wr_data_en),
    .o_ddr3_wr_data_end (ddr3_wr_data_end),
    .o_ddr3_wr_mask     (ddr3_wr_mask),
    .i_ddr3_cmd_ready   (cmd_rdy),
    .i_ddr3_wr_data_rdy (wr_rdy),
    .i_ddr3_rd_data     (rd_data),
    .i_ddr3_rd_data_de  (rd_de),
    .i_ddr3_rd_data_end (rd_end)
  );

  always #5 clk = ~clk;

  // Hard stop if something hangs despite the bounded loops.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic        crdy;
    logic        wrdy;
    logic [1:0]  e_grant;
    logic        e_en;
    logic [27:0] e_addr;
    logic [1:0]  e_wrreq;
    logic [1:0]  e_done;
  } vec_t;

  localparam int NUM_VECS = 17;
  vec_t vecs [NUM_VECS];

  function automatic logic [127:0] pat(input int n);
    return {4{32'hC0DE0000 + n}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ch_req  = v.req;
    ch_wr   = v.wr;
    cmd_rdy = v.crdy;
    wr_rdy  = v.wrdy;
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_grant"},    128'(ch_grant), 128'(0));
    checkOutput({tag, "_cmd_en"},   128'(ddr3_cmd_en), 128'(0));
    checkOutput({tag, "_wd_en"},    128'(ddr3_wr_data_en), 128'(0));
    checkOutput({tag, "_wd_req"},   128'(ch_wr_data_req), 128'(0));
    checkOutput({tag, "_rd_valid"}, 128'(ch_rd_valid), 128'(0));
    checkOutput({tag, "_done"},     128'(ch_done), 128'(0));
    checkOutput({tag, "_cmd"},      128'(ddr3_cmd), 128'(0));
    checkOutput({tag, "_addr"},     128'(ddr3_addr), 128'(0));
    checkOutput({tag, "_mask"},     128'(ddr3_wr_mask), 128'(0));
  endtask

  int            wr_idx;
  int            exp_idx;
  int            g;
  int            n_cmd;
  int            n_ret;
  int            n_de;
  logic          pend;
  logic          drop;
  logic          got_done;
  logic [1:0]    rr_exp [4];
  logic [27:0]   exp_a;

  initial begin
    // Write-burst vectors: rows 0..6 all-ready, rows 7..16 with stalls.
    vecs[0]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 28'h000, 2'b00, 2'b00};
    vecs[1]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 28'h100, 2'b01, 2'b00};
    vecs[2]  = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 28'h108, 2'b01, 2'b00};
    vecs[3]  = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 28'h110, 2'b01, 2'b00};
    vecs[4]  = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 28'h118, 2'b01, 2'b00};
    vecs[5]  = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 28'h000, 2'b00, 2'b01};
    vecs[6]  = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 28'h000, 2'b00, 2'b00};
    vecs[7]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 28'h000, 2'b00, 2'b00};
    vecs[8]  = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 28'h100, 2'b01, 2'b00};
    vecs[9]  = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 28'h000, 2'b00, 2'b00};
    vecs[10] = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 28'h108, 2'b01, 2'b00};
    vecs[11] = '{2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 28'h000, 2'b00, 2'b00};
    vecs[12] = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 28'h110, 2'b01, 2'b00};
    vecs[13] = '{2'b00, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 28'h000, 2'b00, 2'b00};
    vecs[14] = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b1, 28'h118, 2'b01, 2'b00};
    vecs[15] = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 28'h000, 2'b00, 2'b01};
    vecs[16] = '{2'b00, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 28'h000, 2'b00, 2'b00};

`ifdef DDR3_ARB_PRIO0_EN
    rr_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    rst_n      = 1'b0;
    ch_req     = '0;
    ch_wr      = '0;
    ch_addr    = '0;
    ch_wr_data = '0;
    cmd_rdy    = 1'b0;
    wr_rdy     = 1'b0;
    rd_data    = '0;
    rd_de      = 1'b0;
    rd_end     = 1'b0;

    // Reset state.
    tick();
    tick();
    #3;
    check_quiet("reset");
    tick();
    rst_n = 1'b1;

    // Write bursts from the table; client advances data after each wr_data_req.
    wr_idx  = 0;
    exp_idx = 0;
    ch_addr[27:0]    = 28'h100;
    ch_wr_data[255:128] = pat(1000);
    for (int i = 0; i < NUM_VECS; i++) begin
      tick();
      applyStimulus(vecs[i]);
      ch_wr_data[127:0] = pat(wr_idx);
      #3;
      checkOutput($sformatf("v%0d_grant", i),  128'(ch_grant), 128'(vecs[i].e_grant));
      checkOutput($sformatf("v%0d_cmd_en", i), 128'(ddr3_cmd_en), 128'(vecs[i].e_en));
      checkOutput($sformatf("v%0d_wd_en", i),  128'(ddr3_wr_data_en), 128'(vecs[i].e_en));
      checkOutput($sformatf("v%0d_wd_end", i), 128'(ddr3_wr_data_end), 128'(vecs[i].e_en));
      checkOutput($sformatf("v%0d_wd_req", i), 128'(ch_wr_data_req), 128'(vecs[i].e_wrreq));
      checkOutput($sformatf("v%0d_done", i),   128'(ch_done), 128'(vecs[i].e_done));
      if (vecs[i].e_en) begin
        checkOutput($sformatf("v%0d_addr", i),    128'(ddr3_addr), 128'(vecs[i].e_addr));
        checkOutput($sformatf("v%0d_cmd", i),     128'(ddr3_cmd), 128'(3'b000));
        checkOutput($sformatf("v%0d_wr_data", i), ddr3_wr_data, pat(exp_idx));
        exp_idx++;
      end
      if (ch_wr_data_req[0]) wr_idx++;
    end

    // Read on ch1 at the top of the address space, data returning 5 cycles late.
    tick();
    ch_req = 2'b10;
    ch_wr  = 2'b00;
    ch_addr[55:28] = 28'h0FFFFF8;
    ch_addr[55:28] = 28'hFFFFFF8;
    cmd_rdy = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 2) ch_req = 2'b00;
      rd_de   = (c >= 6 && c <= 9);
      rd_data = pat(200 + c - 6);
      #3;
      if (c == 1) checkOutput("rd_grant", 128'(ch_grant), 128'(2'b10));
      checkOutput($sformatf("rd_c%0d_cmd_en", c), 128'(ddr3_cmd_en), 128'(c >= 1 && c <= 4));
      if (c <= 4) begin
        exp_a = 28'hFFFFFF8 + 28'(8 * (c - 1));
        checkOutput($sformatf("rd_c%0d_addr", c), 128'(ddr3_addr), 128'(exp_a));
        checkOutput($sformatf("rd_c%0d_cmd", c),  128'(ddr3_cmd), 128'(3'b001));
      end
      checkOutput($sformatf("rd_c%0d_valid", c), 128'(ch_rd_valid),
                  128'((c >= 7 && c <= 10) ? 2'b10 : 2'b00));
      if (c >= 7 && c <= 10)
        checkOutput($sformatf("rd_c%0d_data", c), ch_rd_data, pat(200 + c - 7));
      checkOutput($sformatf("rd_c%0d_done", c), 128'(ch_done),
                  128'((c == 11) ? 2'b10 : 2'b00));
    end
    rd_de = 1'b0;

    // Both channels requesting continuously.
    tick();
    ch_req = 2'b11;
    ch_wr  = 2'b11;
    ch_addr[27:0]  = 28'h400;
    ch_addr[55:28] = 28'h800;
    wr_rdy = 1'b1;
    g = 0;
    for (int c = 0; c < 100 && g < 4; c++) begin
      tick();
      #3;
      if (ch_grant != 2'b00) begin
        checkOutput($sformatf("rr_grant%0d", g), 128'(ch_grant), 128'(rr_exp[g]));
        g++;
      end
    end
    checkOutput("rr_grants_seen", 128'(g), 128'(4));
    tick();
    ch_req = 2'b00;
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      tick();
      #3;
      if (ch_done != 2'b00) got_done = 1'b1;
    end
    checkOutput("rr_last_done_seen", 128'(got_done), 128'(1));
    tick();

    // Reset with two read beats outstanding (return latency 2).
    ch_req = 2'b01;
    ch_wr  = 2'b00;
    ch_addr[27:0] = 28'h200;
    wr_rdy = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) ch_req = 2'b00;
      rd_de   = (c >= 3);
      rd_data = pat(300 + c);
      #3;
      checkOutput($sformatf("rst_rd_c%0d_cmd_en", c), 128'(ddr3_cmd_en), 128'(1));
    end
    tick();
    rd_de = 1'b0;
    #1;
    checkOutput("pre_reset_rd_valid", 128'(ch_rd_valid), 128'(2'b01));
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      rd_de   = (c < 2);
      rd_data = pat(999);
      #3;
      checkOutput($sformatf("late_de%0d_rd_valid", c), 128'(ch_rd_valid), 128'(0));
      checkOutput($sformatf("late_de%0d_done", c),     128'(ch_done), 128'(0));
    end

    // Next request after reset: ch1 read at 0x300, one-cycle return latency.
    tick();
    rd_de  = 1'b0;
    ch_req = 2'b10;
    ch_wr  = 2'b00;
    ch_addr[55:28] = 28'h300;
    n_cmd = 0;
    n_ret = 0;
    n_de  = 0;
    pend  = 1'b0;
    drop  = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      tick();
      if (drop) ch_req = 2'b00;
      rd_de   = pend;
      rd_data = pat(400 + n_de);
      if (pend) n_de++;
      #3;
      if (ch_grant != 2'b00) begin
        checkOutput("post_reset_grant", 128'(ch_grant), 128'(2'b10));
        drop = 1'b1;
      end
      pend = ddr3_cmd_en;
      if (ddr3_cmd_en) begin
        exp_a = 28'h300 + 28'(8 * n_cmd);
        checkOutput($sformatf("post_reset_addr%0d", n_cmd), 128'(ddr3_addr), 128'(exp_a));
        n_cmd++;
      end
      if (ch_rd_valid != 2'b00) begin
        checkOutput($sformatf("post_reset_valid%0d", n_ret), 128'(ch_rd_valid), 128'(2'b10));
        checkOutput($sformatf("post_reset_data%0d", n_ret),  ch_rd_data, pat(400 + n_ret));
        n_ret++;
      end
      if (ch_done != 2'b00) begin
        checkOutput("post_reset_done", 128'(ch_done), 128'(2'b10));
        got_done = 1'b1;
      end
    end
    checkOutput("post_reset_cmds", 128'(n_cmd), 128'(BL));
    checkOutput("post_reset_beats", 128'(n_ret), 128'(BL));
    checkOutput("post_reset_done_seen", 128'(got_done), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
